// File: rtl/montador_linha_if.sv
// Valid/ready bundle between the beat source, the line assembler and the
// downstream hash stage.
interface montador_linha_if #(
    parameter int unsigned LARGURA_LINHA = 512,
    parameter int unsigned LARGURA_BEAT  = 64
);
    logic [LARGURA_BEAT-1:0]  dado_in;
    logic                     dado_valido;
    logic                     dado_pronto;
    logic                     descarta;
    logic [LARGURA_LINHA-1:0] linha_cache;
    logic                     linha_valida;
    logic                     linha_pronta;

    modport master (
        output dado_in,
        output dado_valido,
        output descarta,
        output linha_pronta,
        input  dado_pronto,
        input  linha_cache,
        input  linha_valida
    );

    modport slave (
        input  dado_in,
        input  dado_valido,
        input  descarta,
        input  linha_pronta,
        output dado_pronto,
        output linha_cache,
        output linha_valida
    );
endinterface

// File: rtl/montador_linha.sv
// Packs LARGURA_BEAT-wide beats into one cache line (first beat in the MSBs)
// and hands the complete line downstream on a valid/ready interface.
module montador_linha #(
    parameter int unsigned LARGURA_LINHA = 512,
    parameter int unsigned LARGURA_BEAT  = 64,
    parameter int unsigned LARGURA_CONT  = 16,
    localparam int unsigned NUM_BEATS     = LARGURA_LINHA / LARGURA_BEAT,
    localparam int unsigned LARGURA_BEATS = $clog2(NUM_BEATS) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    montador_linha_if.slave          bus,
    output logic [LARGURA_BEATS-1:0] beats_recebidos,
    output logic [LARGURA_CONT-1:0]  contador_linhas
);
    typedef enum logic {COLETA, CHEIA} estado_t;

    localparam logic [LARGURA_BEATS-1:0] ULTIMO = LARGURA_BEATS'(NUM_BEATS - 1);
    localparam logic [LARGURA_BEATS-1:0] CHEIO  = LARGURA_BEATS'(NUM_BEATS);

    estado_t                  estado;
    logic [LARGURA_LINHA-1:0] linha_reg;
    logic [LARGURA_LINHA-1:0] linha_escrita;
    logic                     linha_valida_reg;
    logic [LARGURA_BEATS-1:0] slot;

    // A beat accepted during handoff always starts the next line at slot 0.
    assign slot = (estado == CHEIA) ? '0 : beats_recebidos;

    assign bus.dado_pronto  = rst_n & ((estado == COLETA) | bus.linha_pronta);
    assign bus.linha_cache  = linha_reg;
    assign bus.linha_valida = linha_valida_reg;

    always_comb begin
        linha_escrita = linha_reg;
        for (int unsigned i = 0; i < NUM_BEATS; i++) begin
            if (slot == LARGURA_BEATS'(i)) begin
                linha_escrita[LARGURA_LINHA-1-i*LARGURA_BEAT -: LARGURA_BEAT] = bus.dado_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado           <= COLETA;
            linha_reg        <= '0;
            linha_valida_reg <= 1'b0;
            beats_recebidos  <= '0;
            contador_linhas  <= '0;
        end else begin
            unique case (estado)
                COLETA: begin
                    if (bus.descarta) begin
                        beats_recebidos <= '0;
                    end else if (bus.dado_valido) begin
                        linha_reg <= linha_escrita;
                        if (beats_recebidos == ULTIMO) begin
                            estado           <= CHEIA;
                            linha_valida_reg <= 1'b1;
                            beats_recebidos  <= CHEIO;
                        end else begin
                            beats_recebidos <= beats_recebidos + LARGURA_BEATS'(1);
                        end
                    end
                end
                CHEIA: begin
                    if (bus.linha_pronta) begin
                        contador_linhas <= contador_linhas + LARGURA_CONT'(1);
                        if (bus.dado_valido) begin
                            linha_reg <= linha_escrita;
                            // With a single beat per line the new beat is already a full line.
                            if (NUM_BEATS == 1) begin
                                beats_recebidos <= CHEIO;
                            end else begin
                                estado           <= COLETA;
                                linha_valida_reg <= 1'b0;
                                beats_recebidos  <= LARGURA_BEATS'(1);
                            end
                        end else begin
                            estado           <= COLETA;
                            linha_valida_reg <= 1'b0;
                            beats_recebidos  <= '0;
                        end
                    end
                end
                default: begin
                    estado <= COLETA;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_montador_linha.sv
// Directed bench for montador_linha: default 8-beat instance plus a
// single-beat instance with a 4-bit line counter for the wrap case.
module tb_montador_linha;
    logic clk;
    logic rst_n;

    montador_linha_if #(.LARGURA_LINHA(512), .LARGURA_BEAT(64)) b ();
    montador_linha_if #(.LARGURA_LINHA(64),  .LARGURA_BEAT(64)) b2 ();

    logic [3:0]  beats;
    logic [15:0] contador;
    logic [0:0]  beats2;
    logic [3:0]  contador2;

    montador_linha #(.LARGURA_LINHA(512), .LARGURA_BEAT(64), .LARGURA_CONT(16)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (b),
        .beats_recebidos (beats),
        .contador_linhas (contador)
    );

    montador_linha #(.LARGURA_LINHA(64), .LARGURA_BEAT(64), .LARGURA_CONT(4)) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (b2),
        .beats_recebidos (beats2),
        .contador_linhas (contador2)
    );

    int unsigned n_comp = 0;
    int unsigned n_erro = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic verifica(input string tag, input logic [511:0] obs, input logic [511:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_erro++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    function automatic logic [511:0] linha_de(input logic [63:0] base);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l = {l[447:0], base + 64'(i)};
        return l;
    endfunction

    task automatic passo(input logic [63:0] d, input logic v, input logic desc, input logic pr);
        b.dado_in      = d;
        b.dado_valido  = v;
        b.descarta     = desc;
        b.linha_pronta = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic oito_beats(input logic [63:0] base);
        for (int i = 0; i < 8; i++) passo(base + 64'(i), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulso_reset();
        rst_n         = 1'b0;
        b.dado_valido = 1'b0;
        b.descarta    = 1'b0;
        #1;
        verifica("pronto_em_reset", 512'(b.dado_pronto), 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        b.dado_in = '0;  b.dado_valido = 1'b0;  b.descarta = 1'b0;  b.linha_pronta = 1'b0;
        b2.dado_in = '0; b2.dado_valido = 1'b0; b2.descarta = 1'b0; b2.linha_pronta = 1'b0;

        // reset state
        @(posedge clk);
        #1;
        verifica("reset_pronto", 512'(b.dado_pronto), 512'(0));
        verifica("reset_valida", 512'(b.linha_valida), 512'(0));
        verifica("reset_linha", b.linha_cache, 512'(0));
        verifica("reset_beats", 512'(beats), 512'(0));
        verifica("reset_cont", 512'(contador), 512'(0));
        rst_n = 1'b1;

        // basic fill and stall
        for (int i = 1; i <= 7; i++) passo(64'(i), 1'b1, 1'b0, 1'b0);
        verifica("valida_antes_8", 512'(b.linha_valida), 512'(0));
        verifica("beats_7", 512'(beats), 512'(7));
        passo(64'd8, 1'b1, 1'b0, 1'b0);
        verifica("valida_apos_8", 512'(b.linha_valida), 512'(1));
        verifica("beats_cheio", 512'(beats), 512'(8));
        verifica("beat_topo", 512'(b.linha_cache[511:448]), 512'(1));
        verifica("beat_base", 512'(b.linha_cache[63:0]), 512'(8));
        verifica("linha_1_8", b.linha_cache, linha_de(64'd1));
        b.dado_valido = 1'b1;
        b.dado_in     = 64'hDEAD_BEEF_0000_0000;
        #1;
        verifica("pronto_parado", 512'(b.dado_pronto), 512'(0));
        for (int i = 0; i < 10; i++) begin
            passo(64'hDEAD_BEEF_0000_0000 + 64'(i), 1'b1, 1'b0, 1'b0);
            verifica("linha_estavel", b.linha_cache, linha_de(64'd1));
        end
        passo('0, 1'b0, 1'b0, 1'b1);
        verifica("valida_apos_entrega", 512'(b.linha_valida), 512'(0));
        verifica("cont_1", 512'(contador), 512'(1));
        verifica("beats_apos_entrega", 512'(beats), 512'(0));

        // zero-bubble streaming of 24 beats
        pulso_reset();
        begin
            int unsigned nl;
            nl = 0;
            for (int i = 0; i < 24; i++) begin
                b.dado_in = 64'd100 + 64'(i);
                b.dado_valido = 1'b1;
                b.descarta = 1'b0;
                b.linha_pronta = 1'b1;
                #1;
                verifica("pronto_stream", 512'(b.dado_pronto), 512'(1));
                @(posedge clk);
                #1;
                if (i == 8) verifica("beats_pos_handoff", 512'(beats), 512'(1));
                if (b.linha_valida) begin
                    verifica("linha_stream", b.linha_cache, linha_de(64'd100 + 64'(8 * nl)));
                    nl++;
                end
            end
            verifica("linhas_vistas", 512'(nl), 512'(3));
        end
        passo('0, 1'b0, 1'b0, 1'b1);
        verifica("cont_stream", 512'(contador), 512'(3));

        // abort a partial line with a simultaneous beat
        for (int i = 0; i < 5; i++) passo(64'd200 + 64'(i), 1'b1, 1'b0, 1'b0);
        passo(64'd205, 1'b1, 1'b1, 1'b0);
        verifica("beats_descarta", 512'(beats), 512'(0));
        verifica("cont_descarta", 512'(contador), 512'(3));
        oito_beats(64'd300);
        verifica("valida_pos_descarta", 512'(b.linha_valida), 512'(1));
        verifica("linha_pos_descarta", b.linha_cache, linha_de(64'd300));
        passo('0, 1'b0, 1'b0, 1'b1);
        verifica("cont_4", 512'(contador), 512'(4));

        // descarta is ignored while the line is full
        oito_beats(64'd400);
        for (int i = 0; i < 2; i++) begin
            passo('0, 1'b0, 1'b1, 1'b0);
            verifica("valida_descarta_cheia", 512'(b.linha_valida), 512'(1));
            verifica("linha_descarta_cheia", b.linha_cache, linha_de(64'd400));
        end
        passo('0, 1'b0, 1'b1, 1'b1);
        verifica("cont_5", 512'(contador), 512'(5));
        verifica("valida_pos_cheia", 512'(b.linha_valida), 512'(0));
        b.descarta = 1'b0;

        // reset mid-line and while full
        for (int i = 0; i < 4; i++) passo(64'd500 + 64'(i), 1'b1, 1'b0, 1'b0);
        pulso_reset();
        verifica("rst_meio_beats", 512'(beats), 512'(0));
        verifica("rst_meio_valida", 512'(b.linha_valida), 512'(0));
        verifica("rst_meio_linha", b.linha_cache, 512'(0));
        verifica("rst_meio_cont", 512'(contador), 512'(0));
        oito_beats(64'd600);
        verifica("valida_600", 512'(b.linha_valida), 512'(1));
        b.linha_pronta = 1'b1;
        pulso_reset();
        verifica("rst_cheia_cont", 512'(contador), 512'(0));
        verifica("rst_cheia_valida", 512'(b.linha_valida), 512'(0));
        verifica("rst_cheia_linha", b.linha_cache, 512'(0));
        verifica("rst_cheia_beats", 512'(beats), 512'(0));
        b.linha_pronta = 1'b0;
        oito_beats(64'd700);
        verifica("linha_700", b.linha_cache, linha_de(64'd700));
        passo('0, 1'b0, 1'b0, 1'b1);
        verifica("cont_pos_rst", 512'(contador), 512'(1));

        // single-beat lines and counter wrap on the narrow instance
        for (int i = 0; i < 16; i++) begin
            b2.dado_in = 64'(i + 1);
            b2.dado_valido = 1'b1;
            b2.linha_pronta = 1'b1;
            @(posedge clk);
            #1;
            verifica("nb1_valida", 512'(b2.linha_valida), 512'(1));
            verifica("nb1_linha", 512'(b2.linha_cache), 512'(i + 1));
        end
        verifica("nb1_beats", 512'(beats2), 512'(1));
        verifica("nb1_cont_15", 512'(contador2), 512'(15));
        b2.dado_valido = 1'b0;
        @(posedge clk);
        #1;
        verifica("cont_wrap", 512'(contador2), 512'(0));
        verifica("nb1_valida_fim", 512'(b2.linha_valida), 512'(0));
        b2.linha_pronta = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
        $finish;
    end
endmodule
